axi_read_arbiter: RTL and testbench
===================================

Name:
axi_read_arbiter

Overview:
Round-robin arbiter that shares the single AXI4 read channel of the memory port between NUM_PORTS internal read masters, such as the framebuffer stream reader and the TMU texture fetchers. Only one burst is in flight at a time. The grant is held from acceptance of the read address until the RLAST beat completes. The block sits between the RasterIX read masters and the memory-side m_axi read port (axi_ram in simulation, DDR controller on hardware).

Parameters:
NUM_PORTS, 2, number of requesting read masters (2..8).
ADDR_WIDTH, 25, byte address width.
DATA_WIDTH, 32, data bus width in bits (power of two, ≥8).
ID_WIDTH, 8, m_axi_arid/rid width (≥ clog2(NUM_PORTS)).

Ports:
aclk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
s_axi_arvalid  in  NUM_PORTS  per-port read request valid.
s_axi_arready  out  NUM_PORTS  per-port request accept (one-hot or zero).
s_axi_araddr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
s_axi_arlen  in  NUM_PORTS*8  packed burst lengths (beats-1).
s_axi_rvalid  out  NUM_PORTS  per-port data valid.
s_axi_rready  in  NUM_PORTS  per-port data ready.
s_axi_rdata  out  DATA_WIDTH  broadcast read data.
s_axi_rresp  out  2  broadcast response.
s_axi_rlast  out  1  broadcast last beat.
m_axi_arid  out  ID_WIDTH  zero-extended grant index.
m_axi_araddr  out  ADDR_WIDTH  registered address.
m_axi_arlen  out  8  registered length.
m_axi_arsize  out  3  constant clog2(DATA_WIDTH/8).
m_axi_arburst  out  2  constant 2'b01 (INCR).
m_axi_arvalid  out  1  address valid.
m_axi_arready  in  1  address ready.
m_axi_rid  in  ID_WIDTH  ignored (single outstanding burst).
m_axi_rdata  in  DATA_WIDTH  read data.
m_axi_rresp  in  2  read response.
m_axi_rlast  in  1  last beat.
m_axi_rvalid  in  1  data valid.
m_axi_rready  out  1  data ready.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, last_grant=NUM_PORTS-1 so port 0 wins first.
  - grant=0, m_axi_arvalid=0, araddr/arlen/arid registers=0.
  - All s_axi_arready=0 and s_axi_rvalid=0, m_axi_rready=0.
- IDLE:
  - Winner = first asserted s_axi_arvalid scanning last_grant+1, +2, … modulo NUM_PORTS.
  - s_axi_arready[winner]=1 combinationally in the same cycle; this completes the upstream handshake.
  - On that edge, capture the winner's araddr/arlen, set arid=winner, set grant=winner, assert m_axi_arvalid, go to ADDR.
  - No request: stay in IDLE, all s_axi_arready=0.
- ADDR:
  - m_axi_arvalid=1, with address, length and ID held stable.
  - On m_axi_arready=1, deassert arvalid and go to DATA.
  - All s_axi_arready=0.
- DATA:
  - s_axi_rvalid[grant]=m_axi_rvalid; all other ports see 0.
  - m_axi_rready=s_axi_rready[grant].
  - rdata/rresp/rlast pass straight through combinationally (zero latency).
  - On a beat with m_axi_rvalid&m_axi_rready&m_axi_rlast: last_grant=grant, go to IDLE.
- Latency:
  - Upstream accept to m_axi_arvalid: 1 cycle.
  - Minimum gap from a burst's RLAST to the next upstream accept: 1 cycle (the IDLE cycle).
- Outside DATA, m_axi_rready=0; stray rvalid beats are neither accepted nor forwarded.
- Simultaneous requests: exactly one is granted. A requester that keeps arvalid high waits at most NUM_PORTS-1 bursts.
- A port deasserting arvalid before its grant loses its place without side effects. Ports must hold arvalid and their address stable until accepted.
- arlen=0 (single beat): DATA lasts exactly one beat, taken when m_axi_rvalid&m_axi_rready with rlast=1.
- Reset mid-operation: returns to IDLE immediately and the burst is abandoned. The memory slave is reset on the same rst.
- rresp is not interpreted; SLVERR/DECERR are forwarded unchanged.

Test Plan:
- Single request: port 0 asks for araddr=0x100, arlen=3 → s_arready[0] pulses once; next cycle m_arvalid=1, araddr=0x100, arlen=3, arid=0, arsize=2, arburst=1; 4 beats reach port 0 only with rlast on beat 4.
- Simultaneous requests after reset: ports 0 and 1 both request → port 0 is served first; port 1 is accepted in the cycle after port 0's rlast beat, with arid=1.
- Fairness: both ports hold arvalid continuously for 6 single-beat bursts → grant order is 0,1,0,1,0,1.
- Address backpressure: m_arready held low 5 cycles → m_arvalid, araddr and arlen stay stable; no further s_arready pulses; DATA is entered after the handshake.
- Data backpressure: s_rready[grant] toggled 1,0,1,0 → m_rready mirrors it; no beat is lost or duplicated; m_rdata 0xA5A5_0001..0004 arrive in order.
- Reset mid-burst: rst asserted after beat 2 of 4 → m_rready=0, s_rvalid=0 and state IDLE immediately; after release, a port 1 request is served with arid=1.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Read-channel bundles for axi_read_arbiter: the multi-port upstream side
// (one lane per read master) and the single memory-side AXI4 read port.

interface axi_read_arbiter_s_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                 arvalid;
    logic [NUM_PORTS-1:0]                 arready;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] araddr;
    logic [NUM_PORTS-1:0][7:0]            arlen;
    logic [NUM_PORTS-1:0]                 rvalid;
    logic [NUM_PORTS-1:0]                 rready;
    logic [DATA_WIDTH-1:0]                rdata;
    logic [1:0]                           rresp;
    logic                                 rlast;

    modport master (
        output arvalid, araddr, arlen, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );
    modport slave (
        input  arvalid, araddr, arlen, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

interface axi_read_arbiter_m_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    // rid is carried for the memory model but the arbiter never needs it:
    // with a single burst outstanding the returning data always belongs to
    // the current grant.
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between NUM_PORTS masters,
// one burst in flight; the grant is held from AR acceptance to the RLAST beat.

module axi_read_arbiter_lane #(
    parameter int GW  = 1,
    parameter int IDX = 0
) (
    input  logic [GW-1:0] i_win,
    input  logic [GW-1:0] i_grant,
    input  logic          i_accept,
    input  logic          i_data,
    input  logic          i_rvalid,
    output logic          o_arready,
    output logic          o_rvalid
);
    assign o_arready = i_accept && (i_win == GW'(IDX));
    assign o_rvalid  = i_data && (i_grant == GW'(IDX)) && i_rvalid;
endmodule

module axi_read_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                 aclk,
    input  logic                 rst,
    axi_read_arbiter_s_if.slave  s_axi,
    axi_read_arbiter_m_if.master m_axi
);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
    } ar_req_t;

    state_t         r_state, w_next;
    ar_req_t        r_req;
    logic           r_arvalid;
    logic [GW-1:0]  r_grant, r_last_grant;
    logic [GW-1:0]  w_win, w_scan;
    logic           w_found, w_accept, w_data, w_rready, w_last_beat;
    logic [NUM_PORTS-1:0] w_arready, w_rvalid;

    // Scan starts just past the previous winner so every requester is
    // reached within NUM_PORTS-1 bursts.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_scan = GW'((int'(r_last_grant) + k) % NUM_PORTS);
            if (!w_found && s_axi.arvalid[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
    end

    assign w_accept    = (r_state == IDLE) && w_found && !rst;
    assign w_data      = (r_state == DATA) && !rst;
    assign w_rready    = w_data && s_axi.rready[r_grant];
    assign w_last_beat = w_data && m_axi.rvalid && w_rready && m_axi.rlast;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found)        w_next = ADDR;
            ADDR:    if (m_axi.arready)  w_next = DATA;
            DATA:    if (w_last_beat)    w_next = IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_req        <= '0;
            r_arvalid    <= 1'b0;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            if (w_accept) begin
                r_req.id   <= ID_WIDTH'(w_win);
                r_req.addr <= s_axi.araddr[w_win];
                r_req.len  <= s_axi.arlen[w_win];
                r_grant    <= w_win;
                r_arvalid  <= 1'b1;
            end else if (r_state == ADDR && m_axi.arready) begin
                r_arvalid  <= 1'b0;
            end
            if (w_last_beat) r_last_grant <= r_grant;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        axi_read_arbiter_lane #(.GW(GW), .IDX(i)) u_lane (
            .i_win     (w_win),
            .i_grant   (r_grant),
            .i_accept  (w_accept),
            .i_data    (w_data),
            .i_rvalid  (m_axi.rvalid),
            .o_arready (w_arready[i]),
            .o_rvalid  (w_rvalid[i])
        );
    end

    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rdata   = m_axi.rdata;
    assign s_axi.rresp   = m_axi.rresp;
    assign s_axi.rlast   = m_axi.rlast;

    assign m_axi.arid    = r_req.id;
    assign m_axi.araddr  = r_req.addr;
    assign m_axi.arlen   = r_req.len;
    assign m_axi.arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = w_rready;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: two masters, memory side driven by hand.

module tb_axi_read_arbiter;
    localparam int NP = 2;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int IW = 8;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 aclk = ~aclk;

    axi_read_arbiter_s_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    axi_read_arbiter_m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW))  m_if ();

    axi_read_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) u_dut (
        .aclk  (aclk),
        .rst   (rst),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic req(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
        s_if.arvalid[p] = 1'b1;
        s_if.araddr[p]  = addr;
        s_if.arlen[p]   = len;
    endtask

    // Expects port p to win in the current cycle, then walks the AR handshake.
    task automatic expect_accept(input int p, input logic [AW-1:0] addr,
                                 input logic [7:0] len, input bit keep);
        #1;
        chk("s_arready_win", s_if.arready, 64'(1 << p));
        tick();
        if (!keep) s_if.arvalid[p] = 1'b0;
        #1;
        chk("s_arready_addr", s_if.arready, 0);
        chk("m_arvalid", m_if.arvalid, 1);
        chk("m_araddr", m_if.araddr, addr);
        chk("m_arlen", m_if.arlen, len);
        chk("m_arid", m_if.arid, p);
        chk("m_arsize", m_if.arsize, 2);
        chk("m_arburst", m_if.arburst, 1);
        m_if.arready = 1'b1;
        tick();
        m_if.arready = 1'b0;
        #1;
        chk("m_arvalid_drop", m_if.arvalid, 0);
    endtask

    task automatic beats(input int p, input int n, input int total);
        for (int b = 0; b < n; b++) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = 32'hA5A5_0001 + b;
            m_if.rlast  = (b == total - 1);
            s_if.rready[p] = 1'b1;
            #1;
            chk("s_rvalid", s_if.rvalid, 64'(1 << p));
            chk("s_rdata", s_if.rdata, 32'hA5A5_0001 + b);
            chk("s_rlast", s_if.rlast, (b == total - 1));
            chk("m_rready", m_if.rready, 1);
            tick();
        end
        if (n == total) begin
            m_if.rvalid = 1'b0;
            m_if.rlast  = 1'b0;
            #1;
            chk("m_rready_idle", m_if.rready, 0);
        end
    endtask

    initial begin
        int b;
        s_if.arvalid = '0;
        s_if.araddr  = '0;
        s_if.arlen   = '0;
        s_if.rready  = '0;
        m_if.arready = 1'b0;
        m_if.rid     = '0;
        m_if.rdata   = '0;
        m_if.rresp   = 2'b00;
        m_if.rlast   = 1'b0;
        m_if.rvalid  = 1'b0;

        // reset state, with a request pending that must not be accepted
        s_if.arvalid = 2'b01;
        #3;
        chk("rst_s_arready", s_if.arready, 0);
        chk("rst_s_rvalid", s_if.rvalid, 0);
        chk("rst_m_rready", m_if.rready, 0);
        chk("rst_m_arvalid", m_if.arvalid, 0);
        chk("rst_m_araddr", m_if.araddr, 0);
        chk("rst_m_arid", m_if.arid, 0);
        s_if.arvalid = '0;
        tick();
        rst = 1'b0;

        // single request on port 0
        req(0, 25'h100, 8'd3);
        expect_accept(0, 25'h100, 8'd3, 1'b0);
        beats(0, 4, 4);

        // simultaneous requests after reset: 0 first, then 1 right after rlast
        do_reset();
        req(0, 25'h0AA, 8'd1);
        req(1, 25'h0BB, 8'd0);
        expect_accept(0, 25'h0AA, 8'd1, 1'b0);
        beats(0, 2, 2);
        expect_accept(1, 25'h0BB, 8'd0, 1'b0);
        beats(1, 1, 1);

        // fairness with both ports requesting continuously
        req(0, 25'h010, 8'd0);
        req(1, 25'h020, 8'd0);
        for (int i = 0; i < 6; i++) begin
            expect_accept(i % 2, (i % 2) ? 25'h020 : 25'h010, 8'd0, 1'b1);
            beats(i % 2, 1, 1);
        end
        s_if.arvalid = '0;

        // address backpressure, stray rvalid ignored, port 1 waiting
        req(0, 25'h1FF_FFFF, 8'd0);
        #1;
        chk("bpa_s_arready_win", s_if.arready, 1);
        tick();
        s_if.arvalid[0] = 1'b0;
        req(1, 25'h040, 8'd3);
        m_if.rvalid = 1'b1;
        m_if.rdata  = 32'hDEAD_BEEF;
        s_if.rready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bpa_m_arvalid", m_if.arvalid, 1);
            chk("bpa_m_araddr", m_if.araddr, 25'h1FF_FFFF);
            chk("bpa_m_arlen", m_if.arlen, 0);
            chk("bpa_s_arready", s_if.arready, 0);
            chk("bpa_stray_m_rready", m_if.rready, 0);
            chk("bpa_stray_s_rvalid", s_if.rvalid, 0);
            tick();
        end
        m_if.rvalid  = 1'b0;
        m_if.arready = 1'b1;
        tick();
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b1;
        m_if.rdata   = 32'hA5A5_0001;
        m_if.rlast   = 1'b1;
        m_if.rresp   = 2'b10;
        #1;
        chk("bpa_m_arvalid_drop", m_if.arvalid, 0);
        chk("bpa_s_rvalid", s_if.rvalid, 1);
        chk("bpa_s_rresp", s_if.rresp, 2'b10);
        chk("bpa_m_rready", m_if.rready, 1);
        tick();
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
        m_if.rresp  = 2'b00;

        // data backpressure on port 1: rready 1,0,1,0,...
        expect_accept(1, 25'h040, 8'd3, 1'b0);
        b = 0;
        for (int c = 0; c < 20 && b < 4; c++) begin
            s_if.rready[1] = (c % 2 == 0);
            m_if.rvalid = 1'b1;
            m_if.rdata  = 32'hA5A5_0001 + b;
            m_if.rlast  = (b == 3);
            #1;
            chk("bpd_m_rready", m_if.rready, (c % 2 == 0));
            chk("bpd_s_rvalid", s_if.rvalid, 2'b10);
            chk("bpd_s_rdata", s_if.rdata, 32'hA5A5_0001 + b);
            tick();
            if (c % 2 == 0) b++;
        end
        chk("bpd_beat_count", b, 4);
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
        s_if.rready = 2'b11;
        #1;
        chk("bpd_back_idle", m_if.rready, 0);

        // reset in the middle of a 4-beat burst
        req(0, 25'h200, 8'd3);
        expect_accept(0, 25'h200, 8'd3, 1'b0);
        beats(0, 2, 4);
        m_if.rvalid = 1'b1;
        m_if.rdata  = 32'hA5A5_0003;
        req(1, 25'h300, 8'd0);
        rst = 1'b1;
        #1;
        chk("mrst_m_rready", m_if.rready, 0);
        chk("mrst_s_rvalid", s_if.rvalid, 0);
        chk("mrst_m_arvalid", m_if.arvalid, 0);
        chk("mrst_s_arready", s_if.arready, 0);
        tick();
        rst = 1'b0;
        m_if.rvalid = 1'b0;
        expect_accept(1, 25'h300, 8'd0, 1'b0);
        beats(1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
